// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default counter width.
package countdown_timer_pkg;

  // Default counter width, shared with the companion up-counter.
  localparam int unsigned DefaultWidth = 5;

  // Timer states; encodings are fixed so other blocks can decode them.
  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count done pulse and optional auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  // Next-state: load beats enable, enable beats hold; done is a single-edge pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      cnt_d    = cnt_in;
      reload_d = cnt_in;
      state_d  = (cnt_in != '0) ? StRun : StIdle;
    end else if (enab && (state_q == StRun)) begin
      if (cnt_q > One) begin
        cnt_d = cnt_q - One;
      end else begin
        // Terminal count. RUN never holds zero, so cnt_q == 1 here.
        done_d = 1'b1;
        if (AUTO_RELOAD) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
    end
  end

  // State register: asynchronous reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Outputs come straight from registers; busy is a plain state decode.
  assign cnt_out = cnt_q;
  assign done    = done_q;
  assign busy    = (state_q == StRun);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: one-shot and auto-reload instances share stimulus, checked against a model.
module tb_countdown_timer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         enab = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic [W-1:0] cnt_o [2];
  logic         busy_o [2];
  logic         done_o [2];

  // Reference model: index 0 = one-shot, index 1 = auto-reload.
  logic [W-1:0] m_cnt [2];
  logic [W-1:0] m_rel [2];
  logic         m_run [2];
  logic         m_done [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_os (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .cnt_in(cnt_in),
    .cnt_out(cnt_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .cnt_in(cnt_in),
    .cnt_out(cnt_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0; m_rel[i] = '0; m_run[i] = 1'b0; m_done[i] = 1'b0;
    end
  endtask

  // One rising edge of the behavioural timer.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (load) begin
        m_cnt[i] = cnt_in;
        m_rel[i] = cnt_in;
        m_run[i] = (cnt_in != 0);
      end else if (enab && m_run[i]) begin
        if (m_cnt[i] > 1) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else begin
          m_done[i] = 1'b1;
          if (i == 1) m_cnt[i] = m_rel[i];
          else begin
            m_cnt[i] = 0;
            m_run[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // Advance one clock; returns at the following negedge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load = 1'b1; cnt_in = 5'h0b; enab = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    // Assert reset mid-cycle, away from any edge.
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (cnt_o[i] !== 5'h00) begin
        n_bad++; $display("FAIL reset_cnt[%0d] got %h want 00", i, cnt_o[i]);
      end
      n_cmp++;
      if (busy_o[i] !== 1'b0 || done_o[i] !== 1'b0) begin
        n_bad++; $display("FAIL reset_flags[%0d] got busy=%b done=%b want 0/0", i, busy_o[i],
                          done_o[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0; enab = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_cnt [4];
    logic         exp_done [4];
    logic         exp_busy [4];
    exp_cnt  = '{5'h03, 5'h02, 5'h01, 5'h00};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    load = 1'b1; cnt_in = 5'h03; enab = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      load = 1'b0; enab = 1'b1;
      n_cmp++;
      if (cnt_o[0] !== exp_cnt[k] || done_o[0] !== exp_done[k] || busy_o[0] !== exp_busy[k]) begin
        n_bad++;
        $display("FAIL one_shot[%0d] got cnt=%h done=%b busy=%b want cnt=%h done=%b busy=%b", k,
                 cnt_o[0], done_o[0], busy_o[0], exp_cnt[k], exp_done[k], exp_busy[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (cnt_o[0] !== 5'h00 || done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL no_wrap[%0d] got cnt=%h done=%b busy=%b want 00/0/0", k, cnt_o[0],
                 done_o[0], busy_o[0]);
      end
    end
  endtask

  task automatic test_enable_hold();
    load = 1'b1; cnt_in = 5'h05; enab = 1'b0;
    step();
    load = 1'b0; enab = 1'b1;
    step();
    step();
    enab = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (cnt_o[0] !== 5'h03 || busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold[%0d] got cnt=%h busy=%b done=%b want 03/1/0", k, cnt_o[0],
                 busy_o[0], done_o[0]);
      end
    end
    enab = 1'b1;
    step();
    n_cmp++;
    if (cnt_o[0] !== 5'h02) begin
      n_bad++; $display("FAIL resume got %h want 02", cnt_o[0]);
    end
    enab = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_cnt [5];
    logic         exp_done [5];
    exp_cnt  = '{5'h02, 5'h01, 5'h02, 5'h01, 5'h02};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    load = 1'b1; cnt_in = 5'h02; enab = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      load = 1'b0; enab = 1'b1;
      n_cmp++;
      if (cnt_o[1] !== exp_cnt[k] || done_o[1] !== exp_done[k] || busy_o[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL auto_reload[%0d] got cnt=%h done=%b busy=%b want cnt=%h done=%b busy=1",
                 k, cnt_o[1], done_o[1], busy_o[1], exp_cnt[k], exp_done[k]);
      end
    end
    enab = 1'b0;
  endtask

  task automatic test_load_over_terminal();
    load = 1'b1; cnt_in = 5'h02; enab = 1'b0;
    step();
    load = 1'b0; enab = 1'b1;
    step();
    load = 1'b1; cnt_in = 5'h1f; enab = 1'b1;
    step();
    load = 1'b0; enab = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (cnt_o[i] !== 5'h1f || busy_o[i] !== 1'b1 || done_o[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL load_over_tc[%0d] got cnt=%h busy=%b done=%b want 1f/1/0", i, cnt_o[i],
                 busy_o[i], done_o[i]);
      end
    end
  endtask

  task automatic test_zero_and_abort();
    bit saw_done;
    load = 1'b1; cnt_in = 5'h00; enab = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (cnt_o[0] !== 5'h00 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL load_zero got cnt=%h busy=%b done=%b want 00/0/0", cnt_o[0], busy_o[0],
               done_o[0]);
    end
    saw_done = 1'b0;
    load = 1'b1; cnt_in = 5'h04;
    step();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      saw_done |= done_o[0];
    end
    #2 rst = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      saw_done |= done_o[0];
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      saw_done |= done_o[0];
    end
    n_cmp++;
    if (cnt_o[0] !== 5'h00 || busy_o[0] !== 1'b0 || saw_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort got cnt=%h busy=%b saw_done=%b want 00/0/0", cnt_o[0], busy_o[0],
               saw_done);
    end
    enab = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      load   = ($urandom_range(0, 7) == 0);
      enab   = ($urandom_range(0, 3) != 0);
      cnt_in = W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) cnt_in = W'($urandom_range(0, 3));
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (cnt_o[i] !== m_cnt[i] || busy_o[i] !== m_run[i] || done_o[i] !== m_done[i]) begin
          n_bad++;
          $display("FAIL random[%0d][%0d] got cnt=%h busy=%b done=%b want cnt=%h busy=%b done=%b",
                   k, i, cnt_o[i], busy_o[i], done_o[i], m_cnt[i], m_run[i], m_done[i]);
        end
      end
    end
    rst = 1'b0; load = 1'b0; enab = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_enable_hold();
    test_auto_reload();
    test_load_over_terminal();
    test_zero_and_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
